turfio_cout_parallel_gen: RTL



---
 rtl/turfio_cout_parallel_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/turfio_cout_parallel_gen.sv
// COUT nibble generator: streams 32-bit response words MSB-nibble first, one
// nibble per cout_ce_i, filling gaps with an idle word or the training pattern.
module turfio_cout_parallel_gen #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter logic [31:0] IDLE_WORD     = 32'h00000000
) (
  input  logic        aclk_i,
  input  logic        rst_i,
  input  logic        cout_ce_i,
  input  logic        train_i,
  input  logic [31:0] response_i,
  input  logic        response_valid_i,
  output logic        response_ready_o,
  output logic [3:0]  cout_o,
  output logic        cout_valid_o,
  output logic        word_start_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {KIND_IDLE, KIND_DATA, KIND_TRAIN} kind_t;

  logic [2:0]  nib_cnt;
  logic [31:0] sr;
  logic [31:0] hold;
  logic        hold_full;
  kind_t       kind;

  logic        boundary;
  logic        consume;
  logic [31:0] nxt_word;
  kind_t       nxt_kind;

  // Training wins at a boundary but leaves the held response in place.
  always_comb begin
    boundary = cout_ce_i && (nib_cnt == 3'd0);
    consume  = boundary && !train_i && hold_full;
    nxt_word = IDLE_WORD;
    nxt_kind = KIND_IDLE;
    if (train_i) begin
      nxt_word = TRAIN_PATTERN;
      nxt_kind = KIND_TRAIN;
    end else if (hold_full) begin
      nxt_word = hold;
      nxt_kind = KIND_DATA;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      nib_cnt          <= 3'd0;
      sr               <= 32'd0;
      hold             <= 32'd0;
      hold_full        <= 1'b0;
      kind             <= KIND_IDLE;
      cout_o           <= 4'd0;
      cout_valid_o     <= 1'b0;
      word_start_o     <= 1'b0;
      overflow_o       <= 1'b0;
      response_ready_o <= 1'b1;
    end else begin
      cout_valid_o <= cout_ce_i;
      word_start_o <= 1'b0;
      if (cout_ce_i) begin
        if (boundary) begin
          cout_o       <= nxt_word[31:28];
          sr           <= {nxt_word[27:0], 4'h0};
          kind         <= nxt_kind;
          word_start_o <= 1'b1;
        end else begin
          cout_o <= sr[31:28];
          sr     <= {sr[27:0], 4'h0};
        end
        nib_cnt <= nib_cnt + 3'd1;
      end
      // A consume frees the slot in the same edge, so a coincident valid is taken.
      if (response_valid_i && (!hold_full || consume)) begin
        hold             <= response_i;
        hold_full        <= 1'b1;
        response_ready_o <= 1'b0;
      end else if (consume) begin
        hold_full        <= 1'b0;
        response_ready_o <= 1'b1;
      end else if (response_valid_i) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule
